axi_ax_snoop_fifo: RTL and testbench

Buffered successor of the single-cycle AR/AW snooper. It passes one AXI4 address channel (AR or AW) straight through from slave to master and captures a record of every completed address handshake into a parametrised FIFO. It then streams the records one beat each to the stream arbiter, so AXI traffic is decoupled from stream backpressure. It sits between the AXI interconnect and the stream mux, in the same slot as the other snooping submodules.

---
 rtl/axi_ax_snoop_fifo_if.sv | 33 +++
 rtl/axi_ax_snoop_fifo.sv | 120 ++++++++++++
 tb/tb_axi_ax_snoop_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_ax_snoop_fifo_if.sv
// One AXI4 AR or AW address channel, used for both the snooped slave side
// and the forwarded master side of axi_ax_snoop_fifo.
interface axi_ax_snoop_fifo_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 32,
    parameter int BURST_LEN  = 8,
    parameter int LOCK_WIDTH = 2,
    parameter int USER_WIDTH = 64
);
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BURST_LEN-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [LOCK_WIDTH-1:0] lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            region;
    logic [3:0]            qos;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
    logic                  ready;

    modport master (
        output id, addr, len, size, burst, lock, cache, prot, region, qos, user, valid,
        input  ready
    );

    modport slave (
        input  id, addr, len, size, burst, lock, cache, prot, region, qos, user, valid,
        output ready
    );
endinterface

// File: rtl/axi_ax_snoop_fifo.sv
// Address-channel pass-through that buffers a record of every handshake in a FIFO
// and streams the records one beat each. Define AX_SNOOP_DROP_EN to drop instead of stall.
module axi_ax_snoop_fifo #(
    parameter int DATA_WIDTH        = 128,
    parameter int ADDR_WIDTH        = 64,
    parameter int ID_WIDTH          = 32,
    parameter int BURST_LEN         = 8,
    parameter int LOCK_WIDTH        = 2,
    parameter int USER_WIDTH        = 64,
    parameter int STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = '0,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                               clk,
    input  logic                               resetn,
    axi_ax_snoop_fifo_if.slave                 axis,
    axi_ax_snoop_fifo_if.master                axim,
    input  logic                               ready_i,
    output logic                               valid_o,
    output logic                               in_progress_o,
    output logic                               last_o,
    output logic [DATA_WIDTH-1:0]              data_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level_o,
    output logic [15:0]                        drop_count_o
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [PW:0]           wptr_q, wptr_d;
    logic [PW:0]           rptr_q, rptr_d;
    logic [PW:0]           level;
    logic                  full, empty;
    logic                  push, pop;
    logic                  gate;
    logic [DATA_WIDTH-1:0] rec;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    assign axim.id     = axis.id;
    assign axim.addr   = axis.addr;
    assign axim.len    = axis.len;
    assign axim.size   = axis.size;
    assign axim.burst  = axis.burst;
    assign axim.lock   = axis.lock;
    assign axim.cache  = axis.cache;
    assign axim.prot   = axis.prot;
    assign axim.region = axis.region;
    assign axim.qos    = axis.qos;
    assign axim.user   = axis.user;

    assign level = wptr_q - rptr_q;
    assign full  = (level == (PW+1)'(FIFO_DEPTH));
    assign empty = (level == '0);

    // Gating looks only at the registered full flag so ready never depends on ready_i.
`ifdef AX_SNOOP_DROP_EN
    assign gate = resetn;
`else
    assign gate = resetn & ~full;
`endif

    assign axim.valid = axis.valid & gate;
    assign axis.ready = axim.ready & gate;

    assign push = axis.valid & axim.ready & resetn & ~full;
    assign pop  = valid_o & ready_i;

    always_comb begin
        rec = '0;
        rec[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH]                   = STREAM_TYPE;
        rec[DATA_WIDTH-STREAM_TYPE_WIDTH-1 -: ID_WIDTH]          = axis.id;
        rec[DATA_WIDTH-STREAM_TYPE_WIDTH-ID_WIDTH-1 -: BURST_LEN] = axis.len;
        rec[ADDR_WIDTH-1:0]                                      = axis.addr;
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only visible behind a nonzero level.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[PW-1:0]] <= rec;
    end

    assign valid_o       = ~empty;
    assign last_o        = valid_o;
    assign in_progress_o = 1'b0;
    assign data_o        = valid_o ? mem_q[rptr_q[PW-1:0]] : '0;
    assign level_o       = level;

`ifdef AX_SNOOP_DROP_EN
    logic        drop;
    logic [15:0] drop_count_q;

    assign drop = axis.valid & axim.ready & resetn & full;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_count_q <= '0;
        end else if (drop && drop_count_q != 16'hFFFF) begin
            drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign drop_count_o = drop_count_q;
`else
    assign drop_count_o = '0;
`endif
endmodule

// File: tb/tb_axi_ax_snoop_fifo.sv
// Randomised scoreboard bench for axi_ax_snoop_fifo; honours AX_SNOOP_DROP_EN.
module tb_axi_ax_snoop_fifo;
    localparam int D = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    axi_ax_snoop_fifo_if axis_if ();
    axi_ax_snoop_fifo_if axim_if ();

    logic         ready;
    logic         valid, in_progress, last;
    logic [127:0] data;
    logic [2:0]   level;
    logic [15:0]  drop_count;

    axi_ax_snoop_fifo dut (
        .clk           (clk),
        .resetn        (resetn),
        .axis          (axis_if),
        .axim          (axim_if),
        .ready_i       (ready),
        .valid_o       (valid),
        .in_progress_o (in_progress),
        .last_o        (last),
        .data_o        (data),
        .level_o       (level),
        .drop_count_o  (drop_count)
    );

    int errors = 0;
    int checks = 0;

    logic [127:0] sb [$];
    int  lvl = 0;
    int  exp_drop = 0;
    bit  pend_push = 0, pend_pop = 0, pend_drop = 0;
    bit  mon_en = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit exp_gate();
`ifdef AX_SNOOP_DROP_EN
        return 1'b1;
`else
        return lvl < D;
`endif
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("level", level, lvl);
            chk("valid", valid, lvl != 0);
            chk("last", last, lvl != 0);
            chk("in_progress", in_progress, 0);
            chk("axis_ready", axis_if.ready, axim_if.ready & exp_gate());
            chk("axim_valid", axim_if.valid, axis_if.valid & exp_gate());
            chk("axim_addr", axim_if.addr, axis_if.addr);
            chk("axim_id", axim_if.id, axis_if.id);
            chk("drop_count", drop_count, exp_drop);
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    chk("pop_without_record", 1, 0);
                end else begin
                    chk("data", data, sb[0]);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step(input bit v, input bit mr, input bit r,
                        input logic [31:0] id, input logic [7:0] len, input logic [63:0] addr);
        @(posedge clk);
        #1;
        if (pend_push) lvl++;
        if (pend_pop) lvl--;
        if (pend_drop && exp_drop < 65535) exp_drop++;
        axis_if.id     = id;
        axis_if.len    = len;
        axis_if.addr   = addr;
        axis_if.size   = 3'($urandom);
        axis_if.burst  = 2'($urandom);
        axis_if.lock   = 2'($urandom);
        axis_if.cache  = 4'($urandom);
        axis_if.prot   = 3'($urandom);
        axis_if.region = 4'($urandom);
        axis_if.qos    = 4'($urandom);
        axis_if.user   = {$urandom, $urandom};
        axis_if.valid  = v;
        axim_if.ready  = mr;
        ready          = r;
        pend_pop  = (lvl != 0) && r;
        pend_push = v && mr && (lvl < D);
`ifdef AX_SNOOP_DROP_EN
        pend_drop = v && mr && (lvl == D);
`else
        pend_drop = 0;
`endif
        if (pend_push) sb.push_back({3'b000, id, len, 21'd0, addr});
    endtask

    task automatic rstep(input bit v, input bit mr, input bit r);
        step(v, mr, r, $urandom, 8'($urandom), {$urandom, $urandom});
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) rstep(0, 1, 1);
    endtask

    initial begin
        axis_if.valid = 1'b1;
        axis_if.id = 32'h1; axis_if.len = 8'h1; axis_if.addr = 64'h40;
        axis_if.size = '0; axis_if.burst = '0; axis_if.lock = '0; axis_if.cache = '0;
        axis_if.prot = '0; axis_if.region = '0; axis_if.qos = '0; axis_if.user = '0;
        axim_if.ready = 1'b1;
        ready = 1'b1;
        #1;
        chk("rst_axis_ready", axis_if.ready, 0);
        chk("rst_axim_valid", axim_if.valid, 0);
        chk("rst_valid", valid, 0);
        chk("rst_level", level, 0);
        chk("rst_data", data, 0);
        chk("rst_drop", drop_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_held_level", level, 0);
        axis_if.valid = 1'b0;
        resetn = 1'b1;
        mon_en = 1'b1;

        // single transfer
        step(1, 1, 1, 32'h5, 8'h3, 64'h1000);
        rstep(0, 1, 1);
        #3 chk("single_data", data, {3'b000, 32'h5, 8'h3, 21'd0, 64'h1000});
        rstep(0, 1, 1);
        rstep(0, 1, 1);

        // fill beyond depth while stalled, then one pop alongside a new handshake
        for (int i = 0; i < 6; i++) rstep(1, 1, 0);
        rstep(1, 1, 1);
        rstep(1, 1, 0);
        rstep(1, 1, 0);
        drain();

        // backpressure ordering
        step(1, 1, 1, 32'h1, 8'h0, 64'h10);
        step(1, 1, 0, 32'h2, 8'h0, 64'h20);
        step(1, 1, 1, 32'h3, 8'h0, 64'h30);
        rstep(0, 1, 0);
        rstep(0, 1, 1);
        rstep(0, 1, 0);
        rstep(0, 1, 1);
        rstep(0, 1, 0);
        drain();

        // random traffic, first pop-starved then balanced
        for (int i = 0; i < 200; i++) rstep($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(3) == 0);
        for (int i = 0; i < 300; i++) rstep($urandom_range(1), $urandom_range(3) != 0, $urandom_range(3) != 0);
        drain();

        // wrap-around with push/pop pairs
        for (int i = 0; i < 10; i++) rstep(1, 1, 1);
        drain();

        // async reset mid-stream at level 3
        for (int i = 0; i < 3; i++) rstep(1, 1, 0);
        rstep(0, 1, 0);
        #2;
        chk("pre_reset_level", level, 3);
        mon_en = 1'b0;
        axis_if.valid = 1'b1;
        axim_if.ready = 1'b1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_drop", drop_count, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_axis_ready", axis_if.ready, 0);
        chk("mid_rst_axim_valid", axim_if.valid, 0);
        sb.delete();
        lvl = 0; exp_drop = 0;
        pend_push = 0; pend_pop = 0; pend_drop = 0;
        @(posedge clk);
        #1;
        chk("held_rst_level", level, 0);
        chk("held_rst_axis_ready", axis_if.ready, 0);
        axis_if.valid = 1'b0;
        resetn = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 100; i++) rstep($urandom_range(1), 1, $urandom_range(1));
        drain();
        #3;
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
